// File: rtl/fifo_rd_checker.sv
// Purpose : read-side FIFO consumer; drains NUM_WORDS words and checks them against
//           the writer sequence 1..2^FIFO_WIDTH-1,1,.. (zero never sent).
// Latency : each accepted read is compared one clk_r later (dout valid the cycle after ren);
//           done rises on the edge that makes the last compare.
// Backpres: ren only asserted while the FIFO is non-empty. A run of TIMEOUT consecutive
//           starved cycles aborts the run with timeout=1.
// Ports   : clk_r/rst (async, active-high), start pulse, empty/dout from the FIFO,
//           ren to the FIFO, status busy/done/timeout, results rd_cnt/err_cnt,
//           mismatch pulse and first_exp/first_got capture of the first failure.
module fifo_rd_checker #(
   parameter int FIFO_WIDTH = 4,
   parameter int NUM_WORDS  = 16,
   parameter int TIMEOUT    = 64,
   parameter int ERR_W      = 8,
   localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
   input  logic                  clk_r,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  empty,
   input  logic [FIFO_WIDTH-1:0] dout,
   output logic                  ren,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [CNT_W-1:0]      rd_cnt,
   output logic [ERR_W-1:0]      err_cnt,
   output logic                  mismatch,
   output logic [FIFO_WIDTH-1:0] first_exp,
   output logic [FIFO_WIDTH-1:0] first_got
);

   localparam int STALL_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]   NW_V = CNT_W'(NUM_WORDS);
   localparam logic [STALL_W-1:0] TO_V = STALL_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [FIFO_WIDTH-1:0] exp_q, exp_d;
   logic [CNT_W-1:0]      issued_q, issued_d;
   logic                  pend_q, pend_d;
   logic [STALL_W-1:0]    stall_q, stall_d;
   logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
   logic                  timeout_q, timeout_d;
   logic                  mismatch_q, mismatch_d;
   logic [FIFO_WIDTH-1:0] first_exp_q, first_exp_d;
   logic [FIFO_WIDTH-1:0] first_got_q, first_got_d;

   // Reads stop once NUM_WORDS have been issued even if compares are still pending.
   assign ren = (state_q == S_RUN) && !empty && (issued_q < NW_V);

   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign timeout   = timeout_q;
   assign rd_cnt    = rd_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign mismatch  = mismatch_q;
   assign first_exp = first_exp_q;
   assign first_got = first_got_q;

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      issued_d    = issued_q;
      pend_d      = ren;
      stall_d     = stall_q;
      rd_cnt_d    = rd_cnt_q;
      err_cnt_d   = err_cnt_q;
      timeout_d   = timeout_q;
      mismatch_d  = 1'b0;
      first_exp_d = first_exp_q;
      first_got_d = first_got_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_RUN;
               exp_d       = FIFO_WIDTH'(1);
               issued_d    = '0;
               pend_d      = 1'b0;
               stall_d     = '0;
               rd_cnt_d    = '0;
               err_cnt_d   = '0;
               timeout_d   = 1'b0;
               first_exp_d = '0;
               first_got_d = '0;
            end
         end

         S_RUN: begin
            if (ren) begin
               issued_d = issued_q + CNT_W'(1);
               stall_d  = '0;
            end else if (empty && (issued_q < NW_V)) begin
               stall_d = stall_q + STALL_W'(1);
            end

            // Data from the read accepted on the previous edge is on dout now.
            if (pend_q) begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
               exp_d    = (exp_q == '1) ? FIFO_WIDTH'(1) : exp_q + FIFO_WIDTH'(1);
               if (dout != exp_q) begin
                  mismatch_d = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
                  // err_cnt==0 marks the first failure of this run.
                  if (err_cnt_q == '0) begin
                     first_exp_d = exp_q;
                     first_got_d = dout;
                  end
               end
            end

            // Completing the last word takes priority over a coincident timeout.
            if (rd_cnt_d == NW_V) begin
               state_d = S_DONE;
            end else if (stall_d == TO_V) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_r or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         exp_q       <= FIFO_WIDTH'(1);
         issued_q    <= '0;
         pend_q      <= 1'b0;
         stall_q     <= '0;
         rd_cnt_q    <= '0;
         err_cnt_q   <= '0;
         timeout_q   <= 1'b0;
         mismatch_q  <= 1'b0;
         first_exp_q <= '0;
         first_got_q <= '0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         issued_q    <= issued_d;
         pend_q      <= pend_d;
         stall_q     <= stall_d;
         rd_cnt_q    <= rd_cnt_d;
         err_cnt_q   <= err_cnt_d;
         timeout_q   <= timeout_d;
         mismatch_q  <= mismatch_d;
         first_exp_q <= first_exp_d;
         first_got_q <= first_got_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Purpose : directed bench for fifo_rd_checker with a behavioural FIFO and a result scoreboard.
// Latency : FIFO model returns dout one clk_r after an accepted ren.
// Backpres: empty comes from the FIFO fill level, optionally forced high by a toggler.
module tb_fifo_rd_checker;

   localparam int FW = 4;
   localparam int NW = 16;
   localparam int TO = 64;
   localparam int EW = 8;
   localparam int CW = $clog2(NW + 1);

   logic          clk_r = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          empty;
   logic [FW-1:0] dout  = '0;
   logic          ren, busy, done, timeout, mismatch;
   logic [CW-1:0] rd_cnt;
   logic [EW-1:0] err_cnt;
   logic [FW-1:0] first_exp, first_got;

   always #5 clk_r = ~clk_r;

   fifo_rd_checker #(
      .FIFO_WIDTH(FW), .NUM_WORDS(NW), .TIMEOUT(TO), .ERR_W(EW)
   ) dut (
      .clk_r(clk_r), .rst(rst), .start(start), .empty(empty), .dout(dout),
      .ren(ren), .busy(busy), .done(done), .timeout(timeout),
      .rd_cnt(rd_cnt), .err_cnt(err_cnt), .mismatch(mismatch),
      .first_exp(first_exp), .first_got(first_got)
   );

   // Behavioural FIFO: stimulus appends at wr_ptr, reads advance rd_ptr.
   logic [FW-1:0] mem [0:127];
   logic [6:0]    wr_ptr = '0;
   logic [6:0]    rd_ptr = '0;
   logic          force_empty = 1'b0;
   logic          toggle_en   = 1'b0;

   assign empty = (rd_ptr == wr_ptr) || force_empty;

   always @(posedge clk_r) begin
      if (ren) begin
         dout   <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 7'd1;
      end
   end

   // Starves the reader for two cycles out of every four while enabled.
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk_r);
         #1;
         if (toggle_en) begin
            k++;
            if (k % 2 == 0) force_empty = ~force_empty;
         end else begin
            k = 0;
            force_empty = 1'b0;
         end
      end
   end

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   typedef struct {
      int rd; int err; int to; int fe; int fg; int renc; int runc; int tail;
   } res_t;

   res_t exp_q[$];
   int   mm_q[$];

   task automatic push_res(input int rd, input int err, input int to, input int fe,
                           input int fg, input int renc, input int runc, input int tail);
      res_t r;
      r.rd = rd; r.err = err; r.to = to; r.fe = fe; r.fg = fg;
      r.renc = renc; r.runc = runc; r.tail = tail;
      exp_q.push_back(r);
   endtask

   // Appends n words of the writer sequence; index bad_idx is replaced by 0.
   task automatic load_seq(input int n, input int bad_idx);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = (i == bad_idx) ? 4'd0 : FW'((i % 15) + 1);
         wr_ptr = wr_ptr + 7'd1;
      end
   endtask

   task automatic pulse_start();
      @(posedge clk_r);
      #1 start = 1'b1;
      @(posedge clk_r);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk_r);
         n++;
      end
      chk({name, "_done_seen"}, int'(done), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ren"},       int'(ren),       0);
      chk({tag, "_busy"},      int'(busy),      0);
      chk({tag, "_done"},      int'(done),      0);
      chk({tag, "_timeout"},   int'(timeout),   0);
      chk({tag, "_rd_cnt"},    int'(rd_cnt),    0);
      chk({tag, "_err_cnt"},   int'(err_cnt),   0);
      chk({tag, "_mismatch"},  int'(mismatch),  0);
      chk({tag, "_first_exp"}, int'(first_exp), 0);
      chk({tag, "_first_got"}, int'(first_got), 0);
   endtask

   // Monitor: scores every completed run and every mismatch pulse against the queues.
   initial begin
      int   run_c, ren_c, tail_c;
      bit   busy_p, done_p;
      res_t e;
      run_c = 0; ren_c = 0; tail_c = 0; busy_p = 0; done_p = 0;
      forever begin
         @(negedge clk_r);
         if (rst) begin
            run_c = 0; ren_c = 0; tail_c = 0; busy_p = 0; done_p = 0;
         end else begin
            if (busy && !busy_p) begin
               run_c = 0; ren_c = 0; tail_c = 0;
            end
            if (busy) begin
               run_c++;
               if (ren) begin
                  ren_c++;
                  tail_c = 0;
               end else begin
                  tail_c++;
               end
            end
            if (ren) chk("ren_gated_empty_busy", int'({empty, busy}), 1);
            if (mismatch) begin
               if (mm_q.size() == 0) chk("unexpected_mismatch_rd_cnt", int'(rd_cnt), -1);
               else                  chk("mismatch_rd_cnt", int'(rd_cnt), mm_q.pop_front());
            end
            if (done && !done_p) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done_rd_cnt", int'(rd_cnt), -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_rd_cnt",    int'(rd_cnt),    e.rd);
                  chk("res_err_cnt",   int'(err_cnt),   e.err);
                  chk("res_timeout",   int'(timeout),   e.to);
                  chk("res_first_exp", int'(first_exp), e.fe);
                  chk("res_first_got", int'(first_got), e.fg);
                  chk("res_ren_cycles", ren_c,          e.renc);
                  if (e.runc >= 0) chk("res_run_cycles", run_c, e.runc);
                  chk("res_cycles_after_last_ren", tail_c, e.tail);
               end
            end
            busy_p = busy;
            done_p = done;
         end
      end
   end

   initial begin
      int n;

      // Reset held for 3 cycles with an empty FIFO; a start during reset is lost.
      rst = 1'b1;
      repeat (3) @(posedge clk_r);
      #1 start = 1'b1;
      @(posedge clk_r);
      #1;
      check_reset_outputs("t1_reset");
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk_r);
      #1;
      chk("t1_start_with_reset_busy", int'(busy), 0);

      // Full clean run across the 15 -> 1 wrap.
      load_seq(16, -1);
      push_res(16, 0, 0, 0, 0, 16, 17, 1);
      pulse_start();
      wait_done(200, "t2");

      // Fifth word corrupted to zero.
      load_seq(16, 4);
      mm_q.push_back(5);
      push_res(16, 1, 0, 5, 0, 16, 17, 1);
      pulse_start();
      wait_done(200, "t3");

      // Intermittently empty FIFO.
      load_seq(16, -1);
      push_res(16, 0, 0, 0, 0, 16, -1, 1);
      toggle_en = 1'b1;
      pulse_start();
      wait_done(300, "t4");
      toggle_en = 1'b0;

      // Only three words ever arrive: abort after TIMEOUT starved cycles.
      load_seq(3, -1);
      push_res(3, 0, 1, 0, 0, 3, 67, TO);
      pulse_start();
      wait_done(300, "t5");

      // Reset in the middle of a run, then a fresh run from the start of the sequence.
      load_seq(8, -1);
      pulse_start();
      n = 0;
      while (rd_cnt != CW'(8) && n < 100) begin
         @(negedge clk_r);
         n++;
      end
      chk("t6_rd_cnt_before_reset", int'(rd_cnt), 8);
      @(posedge clk_r);
      #1 rst = 1'b1;
      #1;
      check_reset_outputs("t6_midrun_reset");
      @(posedge clk_r);
      #1 rst = 1'b0;
      load_seq(16, -1);
      push_res(16, 0, 0, 0, 0, 16, 17, 1);
      pulse_start();
      wait_done(200, "t6");

      repeat (2) @(negedge clk_r);
      chk("pending_results_left", exp_q.size(), 0);
      chk("pending_mismatches_left", mm_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
